// File: rtl/alu_reservation_station_if.sv
// Dispatch, load-broadcast and result bus of the ALU reservation station.
// Dispatch is valid-only: op_in != 5'b11111 marks a slot, there is no ready; upstream must hold off while rs_full is high.
interface alu_reservation_station_if #(
  parameter int TAG_W = 3
);
  logic [4:0]       op_in;
  logic [31:0]      value1_in;
  logic [31:0]      value2_in;
  logic [TAG_W-1:0] query1_in;
  logic [TAG_W-1:0] query2_in;
  logic [TAG_W-1:0] target_in;
  logic [31:0]      imm_in;
  logic [TAG_W-1:0] mem_num;
  logic [31:0]      mem_value;
  logic             rs_full;
  logic [TAG_W-1:0] alu_num;
  logic [31:0]      alu_value;

  modport master (
    output op_in, value1_in, value2_in, query1_in, query2_in, target_in, imm_in,
    output mem_num, mem_value,
    input  rs_full, alu_num, alu_value
  );

  modport slave (
    input  op_in, value1_in, value2_in, query1_in, query2_in, target_in, imm_in,
    input  mem_num, mem_value,
    output rs_full, alu_num, alu_value
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Reservation station with a built-in single-stage ALU; the result bus doubles
// as the wakeup broadcast for waiting operands.
module alu_reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  alu_reservation_station_if.slave  rs_if
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic             busy;
    logic [4:0]       op;
    logic [31:0]      v1;
    logic [TAG_W-1:0] q1;
    logic [31:0]      v2;
    logic [TAG_W-1:0] q2;
    logic [31:0]      imm;
    logic [TAG_W-1:0] dest;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [TAG_W-1:0] alu_num_q, alu_num_d;
  logic [31:0]      alu_value_q, alu_value_d;

  logic             full;
  logic             issue_vld;
  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W-1:0] free_idx;
  logic             accept;
  entry_t           new_ent;
  entry_t           iss_ent;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op <= 5'd13) || (op == 5'd17) || (op == 5'd26) || (op == 5'd27);
  endfunction

  // Load broadcast takes priority over the ALU broadcast on a tag collision.
  function automatic logic [TAG_W+31:0] wake(
    input logic [TAG_W-1:0] q, input logic [31:0] v,
    input logic [TAG_W-1:0] a_num, input logic [31:0] a_val,
    input logic [TAG_W-1:0] m_num, input logic [31:0] m_val);
    if (q != '0 && m_num != '0 && q == m_num) return {TAG_W'(0), m_val};
    if (q != '0 && a_num != '0 && q == a_num) return {TAG_W'(0), a_val};
    return {q, v};
  endfunction

  function automatic logic [31:0] alu_fn(
    input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] r;
    r = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a & b;
      5'd2:  r = a | b;
      5'd3:  r = a << b[4:0];
      5'd4:  r = a >> b[4:0];
      5'd5:  r = {31'd0, $signed(a) < $signed(b)};
      5'd6:  r = {31'd0, a < b};
      5'd7:  r = $unsigned($signed(a) >>> b[4:0]);
      5'd8:  r = a - b;
      5'd9:  r = a ^ b;
      5'd10: r = {31'd0, a == b};
      5'd11: r = {31'd0, $signed(a) >= $signed(b)};
      5'd12: r = {31'd0, a != b};
      5'd13: r = {31'd0, a >= b};
      5'd17: r = (a + imm) & 32'hFFFF_FFFE;
      5'd26: r = {31'd0, $signed(a) < $signed(b)};
      5'd27: r = {31'd0, a < b};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    ent_d       = ent_q;
    alu_num_d   = '0;
    alu_value_d = alu_value_q;
    full        = 1'b1;
    issue_vld   = 1'b0;
    issue_idx   = '0;
    free_idx    = '0;
    new_ent     = '0;

    // Scan downwards so the lowest index wins for both select and allocate.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      full = full & ent_q[i].busy;
      if (ent_q[i].busy && ent_q[i].q1 == '0 && ent_q[i].q2 == '0) begin
        issue_vld = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (!ent_q[i].busy) free_idx = IDX_W'(i);
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy) begin
        {ent_d[i].q1, ent_d[i].v1} = wake(ent_q[i].q1, ent_q[i].v1, alu_num_q, alu_value_q,
                                          rs_if.mem_num, rs_if.mem_value);
        {ent_d[i].q2, ent_d[i].v2} = wake(ent_q[i].q2, ent_q[i].v2, alu_num_q, alu_value_q,
                                          rs_if.mem_num, rs_if.mem_value);
      end
    end

    iss_ent = ent_q[issue_idx];
    if (issue_vld) begin
      ent_d[issue_idx].busy = 1'b0;
      alu_num_d             = iss_ent.dest;
      alu_value_d           = alu_fn(iss_ent.op, iss_ent.v1, iss_ent.v2, iss_ent.imm);
    end

    // free_idx comes from pre-edge busy bits, so a slot freed by this issue is not reused.
    accept       = is_alu_op(rs_if.op_in) && !full;
    new_ent.busy = 1'b1;
    new_ent.op   = rs_if.op_in;
    new_ent.imm  = rs_if.imm_in;
    new_ent.dest = rs_if.target_in;
    {new_ent.q1, new_ent.v1} = wake(rs_if.query1_in, rs_if.value1_in, alu_num_q, alu_value_q,
                                    rs_if.mem_num, rs_if.mem_value);
    {new_ent.q2, new_ent.v2} = wake(rs_if.query2_in, rs_if.value2_in, alu_num_q, alu_value_q,
                                    rs_if.mem_num, rs_if.mem_value);
    if (accept) ent_d[free_idx] = new_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      alu_num_q   <= '0;
      alu_value_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      alu_num_q   <= alu_num_d;
      alu_value_q <= alu_value_d;
    end
  end

  assign rs_if.rs_full   = full;
  assign rs_if.alu_num   = alu_num_q;
  assign rs_if.alu_value = alu_value_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: expected {tag,value} pairs are
// queued at dispatch and compared in order as results appear on the bus.
module tb_alu_reservation_station;
  localparam int TAG_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_reservation_station_if #(.TAG_W(TAG_W)) bus ();

  alu_reservation_station #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst   (rst_n),
    .rs_if (bus)
  );

  logic [TAG_W+31:0] exp_q[$];
  logic [TAG_W+31:0] mon_e;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      0:  return a + b;
      1:  return a & b;
      2:  return a | b;
      3:  return a << b[4:0];
      4:  return a >> b[4:0];
      5:  return (sa < sb) ? 32'd1 : 32'd0;
      6:  return (a < b) ? 32'd1 : 32'd0;
      7:  return sa >>> b[4:0];
      8:  return a - b;
      9:  return a ^ b;
      10: return (a == b) ? 32'd1 : 32'd0;
      11: return (sa >= sb) ? 32'd1 : 32'd0;
      12: return (a != b) ? 32'd1 : 32'd0;
      13: return (a >= b) ? 32'd1 : 32'd0;
      17: return {a[31:1] + imm[31:1] + {30'd0, a[0] & imm[0]}, 1'b0};
      26: return (sa < sb) ? 32'd1 : 32'd0;
      27: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: results are sampled mid-cycle and checked against the queue head.
  always @(negedge clk) begin
    if (bus.alu_num != '0) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 64'(bus.alu_num), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_tag", 64'(bus.alu_num), 64'(mon_e[TAG_W+31:32]));
        check("result_value", 64'(bus.alu_value), 64'(mon_e[31:0]));
      end
    end
  end

  task automatic push_exp(input logic [TAG_W-1:0] tag, input logic [31:0] val);
    exp_q.push_back({tag, val});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [TAG_W-1:0] q1, input logic [TAG_W-1:0] q2,
                          input logic [TAG_W-1:0] tgt, input logic [31:0] imm);
    bus.op_in = op; bus.value1_in = v1; bus.value2_in = v2;
    bus.query1_in = q1; bus.query2_in = q2; bus.target_in = tgt; bus.imm_in = imm;
    @(posedge clk);
    #1;
    bus.op_in = 5'h1f; bus.query1_in = '0; bus.query2_in = '0;
  endtask

  task automatic mem_pulse(input logic [TAG_W-1:0] tag, input logic [31:0] val);
    bus.mem_num = tag; bus.mem_value = val;
    @(posedge clk);
    #1;
    bus.mem_num = '0; bus.mem_value = '0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [4:0]  ops [17];
    logic [4:0]  op;
    logic [31:0] a, b, im;
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
            5'd10, 5'd11, 5'd12, 5'd13, 5'd17, 5'd26, 5'd27};
    bus.op_in = 5'h1f; bus.value1_in = '0; bus.value2_in = '0; bus.query1_in = '0;
    bus.query2_in = '0; bus.target_in = '0; bus.imm_in = '0;
    bus.mem_num = '0; bus.mem_value = '0;

    // Reset state and first ADD
    repeat (3) @(posedge clk);
    #1;
    check("reset_alu_num", 64'(bus.alu_num), 64'd0);
    check("reset_alu_value", 64'(bus.alu_value), 64'd0);
    check("reset_rs_full", 64'(bus.rs_full), 64'd0);
    rst_n = 1'b1;
    idle(1);
    push_exp(3, 32'd12);
    dispatch(5'd0, 32'd5, 32'd7, 0, 0, 3, 0);
    drain(10);
    check("idle_after_result", 64'(bus.alu_num), 64'd0);

    // Dependency chain through dispatch-time bypass of the ALU broadcast
    push_exp(2, 32'd6);
    dispatch(5'd8, 32'd10, 32'd4, 0, 0, 2, 0);
    idle(1);
    push_exp(4, 32'hF9);
    dispatch(5'd9, 32'd0, 32'hFF, 2, 0, 4, 0);
    drain(10);

    // Load wakeup, fill to full, dropped dispatch, ordered drain
    dispatch(5'd3, 32'd1, 32'd0, 0, 6, 5, 0);
    dispatch(5'd0, 32'd0, 32'd1, 7, 0, 1, 0);
    dispatch(5'd8, 32'd0, 32'd3, 7, 0, 2, 0);
    check("not_full_at_3", 64'(bus.rs_full), 64'd0);
    dispatch(5'd9, 32'd0, 32'hF, 7, 0, 3, 0);
    check("full_at_4", 64'(bus.rs_full), 64'd1);
    dispatch(5'd0, 32'd9, 32'd9, 0, 0, 4, 0);
    check("full_after_drop", 64'(bus.rs_full), 64'd1);
    push_exp(5, 32'd8);
    mem_pulse(6, 32'd35);
    idle(1);
    check("freed_after_issue", 64'(bus.rs_full), 64'd0);
    push_exp(1, 32'd101);
    push_exp(2, 32'd97);
    push_exp(3, 32'h6B);
    mem_pulse(7, 32'd100);
    drain(12);

    // Branches and JALR
    push_exp(1, 32'd1);
    dispatch(5'd26, 32'hFFFF_FFFF, 32'd1, 0, 0, 1, 0);
    push_exp(2, 32'd0);
    dispatch(5'd27, 32'hFFFF_FFFF, 32'd1, 0, 0, 2, 0);
    push_exp(3, 32'd1);
    dispatch(5'd13, 32'd4, 32'd4, 0, 0, 3, 0);
    push_exp(4, 32'h1004);
    dispatch(5'd17, 32'h1001, 32'd0, 0, 0, 4, 32'd4);
    drain(10);

    // Load broadcast beats a same-tag ALU broadcast
    push_exp(2, 32'd2);
    dispatch(5'd0, 32'd1, 32'd1, 0, 0, 2, 0);
    push_exp(3, 32'h55);
    dispatch(5'd2, 32'd0, 32'd0, 2, 0, 3, 0);
    mem_pulse(2, 32'h55);
    drain(10);

    // Non-ALU opcodes allocate nothing
    dispatch(5'd20, 32'd1, 32'd1, 0, 0, 1, 0);
    dispatch(5'h1f, 32'd1, 32'd1, 0, 0, 2, 0);
    dispatch(5'd15, 32'd1, 32'd1, 0, 0, 3, 0);
    dispatch(5'd22, 32'd1, 32'd1, 0, 0, 4, 0);
    idle(3);
    check("ignored_not_full", 64'(bus.rs_full), 64'd0);

    // Simultaneous wakeup: lower index issues first
    for (int i = 1; i <= 4; i++) begin
      dispatch(5'd0, 32'd0, 32'(i), 6, 0, TAG_W'(i), 0);
      if (i == 3) check("oldest_not_full", 64'(bus.rs_full), 64'd0);
    end
    check("oldest_full", 64'(bus.rs_full), 64'd1);
    for (int i = 1; i <= 4; i++) push_exp(TAG_W'(i), 32'(50 + i));
    mem_pulse(6, 32'd50);
    drain(12);

    // Random independent ops, one per cycle
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 16)];
      a  = $urandom();
      b  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom();
      if ($urandom_range(0, 3) == 0) b = a;
      im = $urandom();
      push_exp(TAG_W'((i % 7) + 1), model(op, a, b, im));
      dispatch(op, a, b, 0, 0, TAG_W'((i % 7) + 1), im);
    end
    drain(20);

    // Mid-operation asynchronous reset
    dispatch(5'd0, 32'd1, 32'd1, 6, 0, 1, 0);
    dispatch(5'd0, 32'd2, 32'd2, 6, 0, 2, 0);
    push_exp(5, 32'd30);
    dispatch(5'd0, 32'd10, 32'd20, 0, 0, 5, 0);
    dispatch(5'd0, 32'd3, 32'd4, 0, 0, 4, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_alu_num", 64'(bus.alu_num), 64'd0);
    check("midreset_rs_full", 64'(bus.rs_full), 64'd0);
    check("midreset_alu_value", 64'(bus.alu_value), 64'd0);
    #1;
    rst_n = 1'b1;
    idle(3);
    mem_pulse(6, 32'd7);
    idle(4);
    check("midreset_queue_empty", 64'(exp_q.size()), 64'd0);
    check("midreset_no_stale", 64'(bus.alu_num), 64'd0);
    check("midreset_empty", 64'(bus.rs_full), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Receives dispatched instructions from the reorder buffer's issue port.
- Holds each instruction until both operands are available. Captures missing operands from result broadcasts, tagged by ROB index.
- Issues the oldest ready entry to a built-in one-stage ALU each cycle.
- Returns the result to the ROB on the alu_num/alu_value bus, which also serves as its own wakeup broadcast.

Parameters:
- DEPTH, 4, number of station entries (2..7).
- TAG_W, 3, ROB index width; tag 0 means "no dependency / no result".

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_in  in  5  dispatched opcode; 5'b11111 = no instruction.
- value1_in  in  32  operand 1 value (valid when query1_in == 0).
- value2_in  in  32  operand 2 value, or immediate (valid when query2_in == 0).
- query1_in  in  TAG_W  ROB tag producing operand 1; 0 = ready.
- query2_in  in  TAG_W  ROB tag producing operand 2; 0 = ready.
- target_in  in  TAG_W  ROB index of this instruction.
- imm_in  in  32  immediate; used only by JALR.
- mem_num  in  TAG_W  load broadcast tag; 0 = none.
- mem_value  in  32  load broadcast value.
- rs_full  out  1  all DEPTH entries busy.
- alu_num  out  TAG_W  result tag; 0 = no result this cycle.
- alu_value  out  32  result value.

Behaviour:
- Opcodes accepted: ADD 0, AND 1, OR 2, SLL 3, SRL 4, SLT 5, SLTU 6, SRA 7, SUB 8, XOR 9, BEQ 10, BGE 11, BNE 12, BGEU 13, JALR 17, BLT 26, BLTU 27.
- Any other op_in value, including 5'b11111 and the memory opcodes 18..25, is ignored. Those opcodes belong to the load/store unit.
- Reset (rst low, asynchronous): all entries invalid; alu_num=0; alu_value=0; rs_full=0. Reset during operation discards every pending entry and any result due on the next edge.
- Entry fields: busy, op, v1, q1, v2, q2, imm, dest.
- Insert: an accepted op_in at edge N is written into the lowest-index non-busy entry.
  - When rs_full was high before the edge, the op is dropped and state is unchanged, even if an issue frees an entry at the same edge.
  - Upstream must not dispatch while rs_full is high.
- Wakeup: at each edge, every busy entry with qX != 0 compares qX against alu_num (current output, if nonzero) and against mem_num (if nonzero). On a match: vX <= broadcast value, qX <= 0.
  - The same comparison is applied to the incoming op_in operands (bypass). A dependency broadcast in the dispatch cycle is therefore never lost.
  - If alu_num == mem_num != 0, mem_value wins.
- Ready: busy && q1==0 && q2==0, evaluated on state before the edge. A newly inserted or newly woken entry issues no earlier than the following edge.
- Select/issue: at each edge, the lowest-index ready entry is issued and its entry cleared.
  - Registered outputs after that edge: alu_num = dest, alu_value = f(op, v1, v2, imm).
  - If no entry is ready: alu_num <= 0 and alu_value holds its last value.
  - Latency: ready-to-result is 1 edge; dispatch-to-result minimum is 2 edges.
- ALU functions (32-bit, wrap-around):
  - ADD: v1+v2. SUB: v1-v2.
  - AND/OR/XOR: bitwise.
  - SLL/SRL/SRA: shift v1 by v2[4:0].
  - SLT: signed v1<v2 → 1/0. SLTU: unsigned v1<v2 → 1/0.
  - Branches produce 1 if taken, else 0:
    - BEQ: v1==v2. BNE: v1!=v2.
    - BLT: signed v1<v2. BGE: signed v1>=v2.
    - BLTU: unsigned v1<v2. BGEU: unsigned v1>=v2.
  - JALR: (v1+imm) & 32'hFFFFFFFE.
- rs_full: combinational from entry state; high iff all DEPTH entries are busy.
- Simultaneous events in one edge are all legal: insert + issue + two wakeups. A freed entry is not reused by a same-edge insert.
- Tags are unique while in flight. An entry whose own dest equals a broadcast tag is not affected.

Test Plan:
- Reset: hold rst low, then release → alu_num=0, rs_full=0. Dispatch ADD v1=5, v2=7, q=0, target=3 → two edges later alu_num=3, alu_value=12, then alu_num=0 on the next edge.
- Dependency chain: dispatch SUB target=2 (v1=10, v2=4). Next cycle dispatch XOR target=4 with q1=2, v2=0xFF. The SUB result (2, 6) is broadcast at the same edge that inserts the XOR and is captured via bypass. Next result is alu_num=4, alu_value=0xF9.
- Load wakeup and fill: dispatch SLL target=5, q2=6, v1=1; fill the remaining entries with ops whose q1=7 → rs_full=1. A further dispatch is dropped. Drive mem_num=6, mem_value=35 → next result (5, 8). Drive mem_num=7 → the waiting entries issue in ascending index order, one per cycle.
- Branches and JALR: BLT v1=0xFFFFFFFF, v2=1 → 1. BLTU with the same operands → 0. BGEU 4,4 → 1. JALR v1=0x1001, imm=4 → 0x1004.
- Oldest-first and ignore: two entries become ready at the same edge → the lower index issues first. op_in=LW (20) or 5'b11111 → no entry allocated.
- Mid-operation reset: three busy entries plus a pending result; pulse rst low asynchronously between edges → alu_num=0 immediately, rs_full=0, and no stale result appears after release.
